// File: rtl/fir6_s2p_packer_if.sv
// Serial-sample input and six-lane block output bundle for the FIR feeder.
interface fir6_s2p_packer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             blk_ready;
  logic             blk_valid;
  logic [WIDTH-1:0] x6k;
  logic [WIDTH-1:0] x6k_1;
  logic [WIDTH-1:0] x6k_2;
  logic [WIDTH-1:0] x6k_3;
  logic [WIDTH-1:0] x6k_4;
  logic [WIDTH-1:0] x6k_5;
  logic [CNT_W-1:0] blk_cnt;

  // Upstream sample source / downstream block sink side.
  modport master (
    output in_data, in_valid, flush, blk_ready,
    input  in_ready, blk_valid, x6k, x6k_1, x6k_2, x6k_3, x6k_4, x6k_5, blk_cnt
  );

  // Packer side.
  modport slave (
    input  in_data, in_valid, flush, blk_ready,
    output in_ready, blk_valid, x6k, x6k_1, x6k_2, x6k_3, x6k_4, x6k_5, blk_cnt
  );
endinterface

// File: rtl/fir6_s2p_packer.sv
// Serial-to-parallel packer: groups six samples into one block for the
// 6-parallel FIR, with flush padding of a partial block.
module fir6_s2p_packer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fir6_s2p_packer_if.slave bus
);

  localparam int unsigned LANES = 6;
  localparam int unsigned CW    = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PEND = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_col [LANES];
  logic [CW-1:0]    r_col_cnt;
  logic [WIDTH-1:0] r_x [LANES];
  logic [WIDTH-1:0] w_x_nxt [LANES];
  logic             r_blk_valid;
  logic [CNT_W-1:0] r_blk_cnt;

  logic             w_slot_free;
  logic             w_flush_pend;
  logic             w_in_ready;
  logic             w_accept;
  logic [CW-1:0]    w_cnt_after;
  logic             w_load;

  assign w_slot_free  = !r_blk_valid || bus.blk_ready;
  assign w_flush_pend = (r_state == S_PEND);

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, acceptance and block-load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_in_ready  = rst_n && !w_flush_pend && !((r_col_cnt == CW'(5)) && !w_slot_free);
    w_accept    = bus.in_valid && w_in_ready;
    w_cnt_after = r_col_cnt + CW'(w_accept);
    case (r_state)
      S_IDLE, S_FILL: begin
        if (w_accept && (r_col_cnt == CW'(5))) begin
          w_load      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.flush && (w_cnt_after != CW'(0))) begin
          if (w_slot_free) begin
            w_load      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_PEND;
          end
        end else begin
          w_state_nxt = (w_cnt_after == CW'(0)) ? S_IDLE : S_FILL;
        end
      end
      S_PEND: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Block contents: filled lanes from the collector, the sample arriving now
  // in the next lane, zeros in every lane beyond.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < r_col_cnt) begin
        w_x_nxt[i] = r_col[i];
      end else if ((CW'(i) == r_col_cnt) && w_accept) begin
        w_x_nxt[i] = bus.in_data;
      end else begin
        w_x_nxt[i] = '0;
      end
    end
  end

  // Collector, output block register, valid flag and issue counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        r_col[i] <= '0;
        r_x[i]   <= '0;
      end
      r_col_cnt   <= '0;
      r_blk_valid <= 1'b0;
      r_blk_cnt   <= '0;
    end else if (w_load) begin
      for (int i = 0; i < LANES; i++) begin
        r_x[i] <= w_x_nxt[i];
      end
      r_col_cnt   <= '0;
      r_blk_valid <= 1'b1;
      r_blk_cnt   <= r_blk_cnt + CNT_W'(1);
    end else begin
      if (bus.blk_ready) begin
        r_blk_valid <= 1'b0;
      end
      if (w_accept) begin
        r_col[r_col_cnt] <= bus.in_data;
        r_col_cnt        <= r_col_cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.blk_valid = r_blk_valid;
  assign bus.blk_cnt   = r_blk_cnt;
  assign bus.x6k       = r_x[0];
  assign bus.x6k_1     = r_x[1];
  assign bus.x6k_2     = r_x[2];
  assign bus.x6k_3     = r_x[3];
  assign bus.x6k_4     = r_x[4];
  assign bus.x6k_5     = r_x[5];

endmodule

// File: doc/fir6_s2p_packer.md
Name: fir6_s2p_packer

Overview:
- Upstream feeder for the 6-parallel FIR: collects a serial stream of 16-bit signed samples and packs each group of six consecutive samples into one parallel block on x6k..x6k_5.
- Output block register drives the FIR lane inputs directly.
- Valid/ready handshake on both sides; a flush input pads a partial final block with zeros.

Parameters:
- WIDTH, 16, sample width in bits (two's complement)
- CNT_W, 16, width of the issued-block counter

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  serial sample, signed
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  packer can accept in_data this cycle
- flush  input  1  single-cycle request to close the current partial block
- blk_ready  input  1  downstream consumes the current block this cycle
- blk_valid  output  1  x6k..x6k_5 hold a new, unconsumed block
- x6k  output  WIDTH  lane 0 = first sample of block (sample 6k)
- x6k_1 .. x6k_5  output  WIDTH each  lanes 1..5 = samples 6k+1 .. 6k+5 in arrival order
- blk_cnt  output  CNT_W  number of blocks issued since reset, wraps

Behaviour:
- Reset (async, rst_n low):
  - x6k..x6k_5 = 0, blk_valid = 0, blk_cnt = 0, collector lanes = 0, col_cnt = 0, flush_pend = 0.
  - in_ready = 0 while rst_n is low; after release in_ready = 1 in IDLE.
- Acceptance: a sample is accepted on a cycle with in_valid && in_ready. It is written to collector lane col_cnt, and col_cnt increments 0..5.
- Slot free (slot_free): !blk_valid || blk_ready.
- in_ready = rst_n && !flush_pend && !(col_cnt==5 && !slot_free).
- Block issue on accepting the 6th sample (col_cnt==5):
  - Output register loads lanes 0..4 from the collector and lane 5 from in_data.
  - blk_valid = 1 on the next cycle; col_cnt returns to 0; blk_cnt increments.
  - Latency: 6th sample accepted in cycle t gives the block visible, with blk_valid high, in cycle t+1.
  - Sustained one sample per cycle gives one block every 6 cycles with no bubbles.
- blk_valid falls on the cycle after blk_valid && blk_ready, unless a new block loads in that same cycle, in which case it stays high.
- x6k..x6k_5 hold their last value while blk_valid is low, so the FIR sees stable lanes.
- Flush:
  - Sampled on any cycle.
  - If col_cnt (after this cycle's acceptance) is 1..5, the block closes: unfilled lanes = 0, filled lanes are in arrival order.
  - If the closing sample is the 6th, the block is issued normally and no padding is applied.
  - If col_cnt is 0 and no acceptance this cycle, flush is ignored.
  - If slot_free is false, flush sets flush_pend, which holds in_ready low. The padded block loads on the first cycle slot_free is true; flush_pend then clears.
- State summary:
  - IDLE (col_cnt=0): accept → FILL.
  - FILL (col_cnt 1..5): 6th accept → IDLE with block issue; flush → IDLE with padded issue, or → PEND if the slot is busy.
  - PEND: slot_free → IDLE with padded issue.
- blk_cnt wraps from 2^CNT_W−1 to 0.
- Assertion of rst_n mid-block discards the collector and output contents; no partial block is issued.

Test Plan:
- Stream 1..12 with in_valid=1 and blk_ready=1 → two blocks. Block 1: x6k=1 .. x6k_5=6, blk_valid high in the cycle after sample 6. Block 2: 7..12. blk_cnt=2.
- Signed values −32768, 32767, −1, 0, 5, −5 → lanes carry exact bit patterns, with no sign or order corruption.
- Hold blk_ready=0 after block 1 and stream 7..12 → in_ready drops when col_cnt=5. Sample 12 stalls until blk_ready=1, then block 2 = 7..12 issues one cycle later with no sample lost.
- Accept 100, 200, 300 then pulse flush → block = 100, 200, 300, 0, 0, 0. Flush with col_cnt=0 → no block and blk_cnt unchanged.
- Flush while the previous block is unconsumed → in_ready low, padded block issues the cycle after blk_ready=1.
- Assert rst_n low after 4 samples → all outputs 0, blk_valid 0. After release, a fresh 6-sample block packs from lane 0.
